// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO family.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    localparam int FIFO_DEFAULT_DATA_WIDTH = 8;
    localparam int FIFO_DEFAULT_ADDR_WIDTH = 4;

    // Depth in words for a given address width; yields 0 when the width
    // does not round-trip through clog2, which makes a bad width obvious.
    function automatic int fifo_depth(input int addr_width);
        int depth;
        depth = 1 << addr_width;
        if ($clog2(depth) != addr_width) begin
            return 0;
        end
        return depth;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Dual-port register file: synchronous write, asynchronous read, no reset.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Store the incoming word on an accepted write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky error
// flags and a choice of registered or first-word-fall-through read.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_DEFAULT_ADDR_WIDTH,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = FIFO_MODE_STD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0] ONE       = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Flags come only from the registered count; pointer equality is never
    // used, so full and empty are unambiguous across wrap.
    assign full         = (count_q == DEPTH_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign count        = count_q;

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (mem_rdata)
    );

    // Advance pointers on their accepts and track occupancy.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ONE;
            if (rd_acc) rd_ptr <= rd_ptr + ONE;
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + ONE;
                2'b01:   count_q <= count_q - ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags; a new error wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & full)       overflow <= 1'b1;
            else if (clr_err)       overflow <= 1'b0;
            if (rd_en & empty)      underflow <= 1'b1;
            else if (clr_err)       underflow <= 1'b0;
        end
    end

    generate
        if (FWFT == FIFO_MODE_STD) begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_p0;
            logic                  vld_p0;

            // Registered read: capture the head word and flag it valid for
            // one cycle; the data holds until the next accepted read.
            always_ff @(posedge clk) begin
                if (rst_n) begin
                    rd_data_p0 <= '0;
                    vld_p0     <= 1'b0;
                end else begin
                    vld_p0 <= rd_acc;
                    if (rd_acc) rd_data_p0 <= mem_rdata;
                end
            end

            assign rd_data  = rd_data_p0;
            assign rd_valid = vld_p0;
        end else begin : g_fwft
            // Head word is presented directly; rd_en pops what is shown.
            assign rd_data  = mem_rdata;
            assign rd_valid = ~empty;
        end
    endgenerate

endmodule
